divider_4bit_sched: RTL and testbench
=====================================

// Module: divider_4bit_sched
// PURPOSE
//  Request scheduler wrapped around the combinational 4-bit/2-bit divider.
//  Buffers divide requests in a small FIFO (valid/ready in), drives the head
//  operands to the divider, and registers its quotient/remainder in an output
//  stage (valid/ready out). Intercepts divide-by-zero so the divider result for
//  B==0 is never used.
// PARAMETERS
//  DEPTH  4  request FIFO entries; power of 2, >= 2
//  TAG_W  2  width of the opaque request tag carried with each request
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous reset, active-high
//  in_valid    in   1           request valid
//  in_ready    out  1           request accepted when in_valid && in_ready
//  in_a        in   4           dividend
//  in_b        in   2           divisor
//  in_tag      in   TAG_W       request tag
//  div_a       out  4           dividend to divider (FIFO head)
//  div_b       out  2           divisor to divider (FIFO head)
//  div_result  in   4           quotient from divider (combinational)
//  div_odd     in   4           remainder from divider (combinational)
//  out_valid   out  1           response valid
//  out_ready   in   1           response consumed when out_valid && out_ready
//  out_result  out  4           quotient
//  out_odd     out  4           remainder
//  out_tag     out  TAG_W       tag of the response
//  out_dbz     out  1           response was a divide-by-zero
//  count       out  clog2(D)+1  FIFO occupancy, 0..DEPTH
//  dbz_cnt     out  8           saturating count of dbz responses issued
// BEHAVIOUR
//  Reset: count=0, rd/wr pointers=0, out_valid=0, out_result=out_odd=0,
//  out_tag=0, out_dbz=0, dbz_cnt=0. Reset mid-operation drops all queued
//  and held requests; nothing issues after it.
//  - in_ready = (count < DEPTH). Registered state only; no out_ready path.
//  - Push on accept: entry {a,b,tag} written at wr_ptr, which wraps mod DEPTH.
//  - div_a/div_b = head entry when count>0, else 0.
//  - load = (count>0) && (!out_valid || out_ready). On load: pop head (rd_ptr
//    wraps mod DEPTH), out_valid<=1, out_tag<=head tag.
//    b!=0: out_result<=div_result, out_odd<=div_odd, out_dbz<=0.
//    b==0: out_result<=4'hF, out_odd<=head a, out_dbz<=1, dbz_cnt+1 (holds
//    at 255).
//  - out_valid && out_ready && !load: out_valid<=0, data regs hold.
//  - out_valid && !out_ready: out_* held stable; no load.
//  - Same-cycle push and pop: count unchanged; both pointers advance.
//  - Latency: accept at edge N -> out_valid high in the cycle after edge N+1
//    (2 cycles). Throughput 1/cycle with in_valid=out_ready=1.
//  - Capacity = DEPTH+1 (FIFO plus output reg). No bypass, no overwrite,
//    no drop while not in reset. Responses issue in request order.
// TESTING
//  1 reset, then a=13,b=3,tag=1 -> out_valid 2 cycles later: result=4,
//    odd=1, tag=1, dbz=0.
//  2 out_ready=0, in_valid=1 streaming -> exactly DEPTH+1 (5) accepts, then
//    in_ready=0 with count=4. Release out_ready -> all 5 out in order.
//  3 a=9,b=0 -> result=4'hF, odd=9, dbz=1, dbz_cnt=1. Divider outputs are
//    ignored for this request.
//  4 Random push/pop for 1000 cycles vs. scoreboard with reference quotient
//    and remainder (b!=0) -> all responses match, in order, with pointer
//    wraps exercised.
//  5 Assert rst with 3 queued and out_valid=1 -> next cycle out_valid=0,
//    count=0, in_ready=1, dbz_cnt=0.
//  6 300 back-to-back b=0 requests -> dbz_cnt reaches 255 and holds.

Source files
------------

// File: rtl/divider_4bit_sched_if.sv
// Request/response and divider-side signal bundle for the divider scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface divider_4bit_sched_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
);
  localparam int CntW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [1:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic [3:0]       div_a;
  logic [1:0]       div_b;
  logic [3:0]       div_result;
  logic [3:0]       div_odd;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_result;
  logic [3:0]       out_odd;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic [CntW-1:0]  count;
  logic [7:0]       dbz_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, div_result, div_odd, out_ready,
    output in_ready, div_a, div_b, out_valid, out_result, out_odd, out_tag,
           out_dbz, count, dbz_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, div_result, div_odd, out_ready,
    input  in_ready, div_a, div_b, out_valid, out_result, out_odd, out_tag,
           out_dbz, count, dbz_cnt
  );
endinterface

// File: rtl/divider_4bit_sched.sv
// Request FIFO plus registered output stage around an external combinational
// 4-bit/2-bit divider; divide-by-zero requests bypass the divider result.
module divider_4bit_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input logic                  clk,
  input logic                  rst,
  divider_4bit_sched_if.slave  bus
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [3:0]       memA_q   [DEPTH];
  logic [1:0]       memB_q   [DEPTH];
  logic [TAG_W-1:0] memTag_q [DEPTH];

  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             outValid_q, outValid_d;
  logic [3:0]       outResult_q, outResult_d;
  logic [3:0]       outOdd_q, outOdd_d;
  logic [TAG_W-1:0] outTag_q, outTag_d;
  logic             outDbz_q, outDbz_d;
  logic [7:0]       dbzCnt_q, dbzCnt_d;

  logic             push;
  logic             load;
  logic             headValid;
  logic [3:0]       headA;
  logic [1:0]       headB;
  logic [TAG_W-1:0] headTag;

  assign headValid = (count_q != '0);
  assign headA     = memA_q[rdPtr_q];
  assign headB     = memB_q[rdPtr_q];
  assign headTag   = memTag_q[rdPtr_q];

  assign push = bus.in_valid && (count_q < DepthC);
  assign load = headValid && (!outValid_q || bus.out_ready);

  assign bus.in_ready   = (count_q < DepthC);
  assign bus.div_a      = headValid ? headA : 4'h0;
  assign bus.div_b      = headValid ? headB : 2'b00;
  assign bus.out_valid  = outValid_q;
  assign bus.out_result = outResult_q;
  assign bus.out_odd    = outOdd_q;
  assign bus.out_tag    = outTag_q;
  assign bus.out_dbz    = outDbz_q;
  assign bus.count      = count_q;
  assign bus.dbz_cnt    = dbzCnt_q;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    outValid_d  = outValid_q;
    outResult_d = outResult_q;
    outOdd_d    = outOdd_q;
    outTag_d    = outTag_q;
    outDbz_d    = outDbz_q;
    dbzCnt_d    = dbzCnt_q;

    if (push) begin
      wrPtr_d = wrPtr_q + PtrW'(1);
    end

    // A zero divisor never consumes the divider outputs.
    if (load) begin
      rdPtr_d    = rdPtr_q + PtrW'(1);
      outValid_d = 1'b1;
      outTag_d   = headTag;
      if (headB == 2'b00) begin
        outResult_d = 4'hF;
        outOdd_d    = headA;
        outDbz_d    = 1'b1;
        if (dbzCnt_q != 8'hFF) begin
          dbzCnt_d = dbzCnt_q + 8'd1;
        end
      end else begin
        outResult_d = bus.div_result;
        outOdd_d    = bus.div_odd;
        outDbz_d    = 1'b0;
      end
    end else if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      outValid_q  <= 1'b0;
      outResult_q <= 4'h0;
      outOdd_q    <= 4'h0;
      outTag_q    <= '0;
      outDbz_q    <= 1'b0;
      dbzCnt_q    <= 8'h00;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      outValid_q  <= outValid_d;
      outResult_q <= outResult_d;
      outOdd_q    <= outOdd_d;
      outTag_q    <= outTag_d;
      outDbz_q    <= outDbz_d;
      dbzCnt_q    <= dbzCnt_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wrPtr_q]   <= bus.in_a;
      memB_q[wrPtr_q]   <= bus.in_b;
      memTag_q[wrPtr_q] <= bus.in_tag;
    end
  end
endmodule

// File: tb/tb_divider_4bit_sched.sv
// Randomized self-checking bench for divider_4bit_sched against an in-order
// queue of expected responses computed with plain arithmetic.
module tb_divider_4bit_sched;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  typedef struct {
    logic [3:0]       res;
    logic [3:0]       odd;
    logic [TAG_W-1:0] tag;
    logic             dbz;
  } resp_t;

  logic clk;
  logic rst;
  logic [7:0] junk;
  int testsRun;
  int testsFailed;
  int dbzConsumed;
  int accepts;
  int consumed;
  resp_t expQ[$];

  divider_4bit_sched_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  divider_4bit_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in divider; returns noise for a zero divisor so misuse is visible.
  always_comb begin
    if (bus.div_b == 2'b00) begin
      bus.div_result = junk[3:0];
      bus.div_odd    = junk[7:4];
    end else begin
      bus.div_result = bus.div_a / {2'b00, bus.div_b};
      bus.div_odd    = bus.div_a % {2'b00, bus.div_b};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a,
                               input logic [1:0] b, input logic [TAG_W-1:0] t,
                               input logic ordy);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = t;
    bus.out_ready = ordy;
  endtask

  // Called at a negedge with inputs already applied; advances one clock.
  task automatic tick();
    resp_t r;
    resp_t e;
    int outstanding;
    outstanding = expQ.size();
    checkOutput("occupancy", 32'(bus.count) + 32'(bus.out_valid), 32'(outstanding));
    checkOutput("in_ready", 32'(bus.in_ready),
                32'((outstanding - int'(bus.out_valid)) < DEPTH));
    if (bus.out_valid && bus.out_ready) begin
      consumed++;
      if (expQ.size() == 0) begin
        checkOutput("spurious_resp", 32'(1), 32'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("resp_result", 32'(bus.out_result), 32'(e.res));
        checkOutput("resp_odd", 32'(bus.out_odd), 32'(e.odd));
        checkOutput("resp_tag", 32'(bus.out_tag), 32'(e.tag));
        checkOutput("resp_dbz", 32'(bus.out_dbz), 32'(e.dbz));
        if (e.dbz) dbzConsumed++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      accepts++;
      r.tag = bus.in_tag;
      if (bus.in_b == 2'b00) begin
        r.res = 4'hF;
        r.odd = bus.in_a;
        r.dbz = 1'b1;
      end else begin
        r.res = 4'(int'(bus.in_a) / int'(bus.in_b));
        r.odd = 4'(int'(bus.in_a) % int'(bus.in_b));
        r.dbz = 1'b0;
      end
      expQ.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    junk = 8'($urandom);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'h0, 2'b00, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    dbzConsumed = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    applyStimulus(1'b0, 4'h0, 2'b00, '0, 1'b1);
    while ((expQ.size() != 0 || bus.out_valid) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'(0));
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("dbz_cnt_model", 32'(bus.dbz_cnt),
                32'((dbzConsumed > 255) ? 255 : dbzConsumed));
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    junk = 8'h5A;
    testsRun = 0;
    testsFailed = 0;
    dbzConsumed = 0;
    applyStimulus(1'b0, 4'h0, 2'b00, '0, 1'b0);
    @(negedge clk);
    doReset();

    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("rst_count", 32'(bus.count), 32'(0));
    checkOutput("rst_out_result", 32'(bus.out_result), 32'(0));
    checkOutput("rst_out_odd", 32'(bus.out_odd), 32'(0));
    checkOutput("rst_out_tag", 32'(bus.out_tag), 32'(0));
    checkOutput("rst_out_dbz", 32'(bus.out_dbz), 32'(0));
    checkOutput("rst_dbz_cnt", 32'(bus.dbz_cnt), 32'(0));
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Single request: 13 / 3, two-cycle latency.
    applyStimulus(1'b1, 4'd13, 2'd3, 2'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, '0, 1'b0);
    checkOutput("t1_not_yet", 32'(bus.out_valid), 32'(0));
    tick();
    checkOutput("t1_valid", 32'(bus.out_valid), 32'(1));
    checkOutput("t1_result", 32'(bus.out_result), 32'(4));
    checkOutput("t1_odd", 32'(bus.out_odd), 32'(1));
    checkOutput("t1_tag", 32'(bus.out_tag), 32'(1));
    checkOutput("t1_dbz", 32'(bus.out_dbz), 32'(0));
    drain(10);

    // Back-pressure: exactly DEPTH+1 accepts, then full.
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'($urandom), 2'($urandom_range(1, 3)), 2'(i), 1'b0);
      tick();
    end
    checkOutput("t2_accepts", 32'(accepts), 32'(DEPTH + 1));
    checkOutput("t2_in_ready", 32'(bus.in_ready), 32'(0));
    checkOutput("t2_count", 32'(bus.count), 32'(DEPTH));
    consumed = 0;
    drain(20);
    checkOutput("t2_consumed", 32'(consumed), 32'(DEPTH + 1));

    // Divide by zero, held at the output.
    applyStimulus(1'b1, 4'd9, 2'd0, 2'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, '0, 1'b0);
    tick();
    checkOutput("t3_valid", 32'(bus.out_valid), 32'(1));
    checkOutput("t3_result", 32'(bus.out_result), 32'(4'hF));
    checkOutput("t3_odd", 32'(bus.out_odd), 32'(9));
    checkOutput("t3_dbz", 32'(bus.out_dbz), 32'(1));
    checkOutput("t3_dbz_cnt", 32'(bus.dbz_cnt), 32'(1));

    // Reset with three queued requests behind a held response.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'($urandom), 2'($urandom), 2'(i), 1'b0);
      tick();
    end
    checkOutput("t5_pre_count", 32'(bus.count), 32'(3));
    checkOutput("t5_pre_valid", 32'(bus.out_valid), 32'(1));
    doReset();
    checkOutput("t5_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("t5_count", 32'(bus.count), 32'(0));
    checkOutput("t5_in_ready", 32'(bus.in_ready), 32'(1));
    checkOutput("t5_dbz_cnt", 32'(bus.dbz_cnt), 32'(0));
    applyStimulus(1'b0, 4'h0, 2'b00, '0, 1'b1);
    tick();
    tick();
    checkOutput("t5_nothing_issues", 32'(bus.out_valid), 32'(0));

    // Random traffic against the reference queue.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), 4'($urandom), 2'($urandom),
                    2'($urandom), 1'($urandom_range(0, 99) < 55));
      tick();
    end
    drain(30);

    // Saturation of the divide-by-zero counter.
    doReset();
    accepts = 0;
    cnt = 0;
    while (accepts < 300 && cnt < 400) begin
      applyStimulus(1'b1, 4'($urandom), 2'b00, 2'($urandom), 1'b1);
      tick();
      cnt++;
    end
    checkOutput("t6_accepts", 32'(accepts), 32'(300));
    drain(20);
    checkOutput("t6_dbz_sat", 32'(bus.dbz_cnt), 32'(255));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
